uart_rx: RTL and testbench

- Asynchronous serial receiver that sits directly upstream of s3g_rx.
- Converts the host UART line (8N1, LSB first) into byte strobes.
- Drives s3g_rx's rx_data/rx_done inputs: rx_done is a one-clock pulse with rx_data valid in that cycle.
- Uses 16x oversampling with 3-sample majority voting; reports framing errors separately.

---
 rtl/uart_rx_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM states, oversampling
// geometry, arming length and the 3-sample majority vote.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int ARM_TICKS  = 16;
  localparam int DATA_BITS  = 8;

  // Tick indices within a bit at which the line is sampled (mid-bit).
  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;

  localparam logic [3:0] IDX_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] ARM_LAST = 4'(ARM_TICKS - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  // Two-of-three vote; suppresses a single corrupted sample.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every BAUD_DIV clocks. The
// clear input restarts the count so the tick phase can be aligned to a
// detected start edge. Shared by the receive and transmit paths.
module uart_baud_tick #(
  parameter int BAUD_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  // Next count: restart on clear or terminal count, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit 3-sample majority
// voting. Produces a one-clock rx_done strobe with the byte, or a
// one-clock rx_frame_err strobe when the stop bit is low. After reset or
// a framing error the receiver must see the line idle high for a full
// bit time before it accepts a start edge.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  logic       rx_meta_q, rxs_q, rxs_prev_q;
  rx_state_e  state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] bit_q, bit_d;
  logic       armed_q, armed_d;
  logic [3:0] arm_cnt_q, arm_cnt_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       samp_a_q, samp_b_q;
  logic [7:0] shreg_q;

  logic tick, clear, start_edge, vote, shift_en;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  assign start_edge = rxs_prev_q & ~rxs_q;
  assign vote       = majority3(samp_a_q, samp_b_q, rxs_q);
  assign shift_en   = tick && (state_q == DATA) && (idx_q == SAMPLE_C);

  assign rx_data      = data_q;
  assign rx_done      = done_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = (state_q != IDLE);

  // Two-stage synchronizer plus a delayed copy for falling-edge detection;
  // all held at the idle (high) line level in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Arming, frame sequencing and output strobes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bit_d     = bit_q;
    armed_d   = armed_q;
    arm_cnt_d = arm_cnt_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    clear     = 1'b0;

    // Count consecutive high ticks; any low tick restarts the count.
    if (tick) begin
      if (!rxs_q) begin
        arm_cnt_d = '0;
      end else if (arm_cnt_q == ARM_LAST) begin
        armed_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + 4'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (armed_q && start_edge) begin
          clear   = 1'b1;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          idx_d = idx_q + 4'd1;
          if ((idx_q == SAMPLE_C) && vote) begin
            state_d = IDLE;
          end else if (idx_q == IDX_LAST) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == IDX_LAST) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so a following start edge is not missed.
        if (tick) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == SAMPLE_C) begin
            state_d = IDLE;
            if (vote) begin
              data_d = shreg_q;
              done_d = 1'b1;
            end else begin
              err_d     = 1'b1;
              armed_d   = 1'b0;
              arm_cnt_d = '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      bit_q     <= '0;
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bit_q     <= bit_d;
      armed_q   <= armed_d;
      arm_cnt_q <= arm_cnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Sample capture and LSB-first shift register; fully rewritten each frame.
  always_ff @(posedge clk) begin
    if (tick && (idx_q == SAMPLE_A)) begin
      samp_a_q <= rxs_q;
    end
    if (tick && (idx_q == SAMPLE_B)) begin
      samp_b_q <= rxs_q;
    end
    if (shift_en) begin
      shreg_q <= {vote, shreg_q[7:1]};
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=4 (one bit = 64 clk).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  BD      = 4;
  localparam int  BIT_CLK = 16 * BD;
  localparam int  LAT     = 154 * BD + 3;
  localparam time PER     = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #(PER / 2) clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse monitor.
  logic [7:0] got_q[$];
  int         err_pulses  = 0;
  int         both_cnt    = 0;
  int         data_glitch = 0;
  int         since_done  = 100;
  logic       busy_after  = 1'b1;
  logic [7:0] prev_data   = 8'h00;
  time        t_done      = 0;
  time        t_fall      = 0;

  always @(negedge clk) begin
    if (rx_done) begin
      got_q.push_back(rx_data);
      t_done     = $time;
      since_done = 0;
    end else if (since_done < 100) begin
      since_done++;
    end
    if (since_done == 2) busy_after = rx_busy;
    if (rx_frame_err) err_pulses++;
    if (rx_done && rx_frame_err) both_cnt++;
    if (rst && (rx_data !== prev_data) && !rx_done) data_glitch++;
    prev_data = rx_data;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Drives one frame starting at the current negedge; optional noise pulse
  // over sample index 8 of data bit noise_bit, optional reset pulse inside
  // data bit rst_bit.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int noise_bit, input int rst_bit);
    logic [9:0] fr;
    fr     = {stop, b, 1'b0};
    t_fall = $time;
    for (int j = 0; j < 10; j++) begin
      for (int m = 0; m < BIT_CLK; m++) begin
        rx = fr[j];
        if (noise_bit >= 0 && (j - 1) == noise_bit && m >= 34 && m <= 37) rx = ~fr[j];
        if (rst_bit >= 0 && (j - 1) == rst_bit) begin
          if (m == 10) rst = 1'b0;
          if (m == 18) rst = 1'b1;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #(PER * 100000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0, e0, lat, waited;
    logic saw_busy;

    vecs[0] = '{8'hD5, 1'b1, 1'b1, 1'b0, 8'hD5};
    vecs[1] = '{8'h0D, 1'b1, 1'b1, 1'b0, 8'h0D};
    vecs[2] = '{8'hD5, 1'b1, 1'b1, 1'b0, 8'hD5};
    vecs[3] = '{8'h03, 1'b1, 1'b1, 1'b0, 8'h03};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};
    vecs[5] = '{8'h02, 1'b1, 1'b1, 1'b0, 8'h02};
    vecs[6] = '{8'h03, 1'b1, 1'b1, 1'b0, 8'h03};
    vecs[7] = '{8'hCC, 1'b1, 1'b1, 1'b0, 8'hCC};
    vecs[8] = '{8'h03, 1'b1, 1'b1, 1'b0, 8'h03};
    vecs[9] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h03};

    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_done", 32'(rx_done), 32'h0);
    check("reset_rx_frame_err", 32'(rx_frame_err), 32'h0);
    check("reset_rx_busy", 32'(rx_busy), 32'h0);
    rst = 1'b1;
    idle(100);

    // Single byte followed by back-to-back frames, then a good byte and a
    // frame with a low stop bit.
    for (int i = 0; i < 10; i++) begin
      n0 = got_q.size();
      e0 = err_pulses;
      busy_after = 1'b1;
      send_frame(vecs[i].data, vecs[i].stop, -1, -1);
      check($sformatf("v%0d_done_count", i), 32'(got_q.size() - n0), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_err_count", i), 32'(err_pulses - e0), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      if (vecs[i].exp_done && got_q.size() > n0) begin
        check($sformatf("v%0d_byte", i), 32'(got_q[got_q.size() - 1]), 32'(vecs[i].exp_data));
        lat = int'((t_done - t_fall) / PER);
        check($sformatf("v%0d_latency_in_window", i),
              32'((lat >= LAT - 2) && (lat <= LAT + 2)), 32'h1);
        check($sformatf("v%0d_busy_after_done", i), 32'(busy_after), 32'h0);
      end
    end

    // Line held low (break) after the framing error: no pulses, then a
    // byte after one idle bit time is accepted.
    n0 = got_q.size();
    e0 = err_pulses;
    rx = 1'b0;
    repeat (200) @(negedge clk);
    check("break_no_done", 32'(got_q.size() - n0), 32'h0);
    check("break_no_err", 32'(err_pulses - e0), 32'h0);
    idle(64);
    send_frame(8'hA5, 1'b1, -1, -1);
    check("after_break_done_count", 32'(got_q.size() - n0), 32'h1);
    check("after_break_byte", 32'(rx_data), 32'hA5);
    check("after_break_no_err", 32'(err_pulses - e0), 32'h0);

    // Start glitch of 3 ticks.
    idle(64);
    n0 = got_q.size();
    e0 = err_pulses;
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
    end
    rx = 1'b1;
    waited = 0;
    while (rx_busy && waited < 40) begin
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
      waited++;
    end
    check("glitch_busy_seen", 32'(saw_busy), 32'h1);
    check("glitch_busy_drop", 32'(rx_busy), 32'h0);
    idle(BIT_CLK);
    check("glitch_no_done", 32'(got_q.size() - n0), 32'h0);
    check("glitch_no_err", 32'(err_pulses - e0), 32'h0);

    // Noise on sample index 8 of data bit 3.
    n0 = got_q.size();
    e0 = err_pulses;
    send_frame(8'hA5, 1'b1, 3, -1);
    check("noise_done_count", 32'(got_q.size() - n0), 32'h1);
    check("noise_byte", 32'(rx_data), 32'hA5);
    check("noise_no_err", 32'(err_pulses - e0), 32'h0);

    // Reset in the middle of data bit 4 of 0x0F while the line is low.
    idle(64);
    n0 = got_q.size();
    e0 = err_pulses;
    send_frame(8'h0F, 1'b1, -1, 4);
    check("midreset_no_done", 32'(got_q.size() - n0), 32'h0);
    check("midreset_no_err", 32'(err_pulses - e0), 32'h0);
    check("midreset_data_cleared", 32'(rx_data), 32'h00);
    idle(64);
    send_frame(8'hCC, 1'b1, -1, -1);
    check("post_reset_done_count", 32'(got_q.size() - n0), 32'h1);
    check("post_reset_byte", 32'(rx_data), 32'hCC);
    check("post_reset_no_err", 32'(err_pulses - e0), 32'h0);

    idle(20);
    check("done_err_exclusive", 32'(both_cnt), 32'h0);
    check("rx_data_stable", 32'(data_glitch), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
